// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU load/store datapath, the memory access unit and
// the data SRAM. The unit sits behind the "slave" modport. The "master"
// modport drives both the CPU request side and the SRAM read data.
//
// Handshake: the CPU holds req with wr/size/sext/addr/wdata stable. The unit
// samples them only on a clock edge where busy is low. It answers each
// accepted request with exactly one single-cycle ack, with addr_err
// qualifying that ack. A request held high across ack is accepted again in
// the first idle cycle after it.
interface mem_access_unit_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        ack;
   logic        addr_err;
   logic [31:0] rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport slave (
      input  req, wr, size, sext, addr, wdata, data_sram_rdata,
      output busy, ack, addr_err, rdata,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

   modport master (
      output req, wr, size, sext, addr, wdata, data_sram_rdata,
      input  busy, ack, addr_err, rdata,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Data-side memory access unit. It takes one byte, halfword or word request
// at a time and drives the synchronous data SRAM. For stores it produces byte
// enables and lane-replicated data. For loads it waits RD_LAT cycles, then
// returns the extracted lane, sign- or zero-extended. Misaligned requests
// finish with addr_err and never touch the SRAM.
module mem_access_unit #(
   parameter int RD_LAT = 1   // SRAM read latency, 1..4 cycles
) (
   input  logic             clk,
   input  logic             resetn,
   mem_access_unit_if.slave bus,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] sram_addr_q, sram_addr_d;
   logic [31:0] sram_wdata_q, sram_wdata_d;
   logic        accept;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_rep;

   // Request fields held for the duration of one transaction.
   logic        wr_q, sext_q, err_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [3:0]  be_q;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // Decode the incoming request: alignment, byte enables and replicated data.
   always_comb begin
      misaligned = 1'b0;
      be_new     = 4'b1111;
      wdata_rep  = bus.wdata;
      case (bus.size)
         2'b00: begin
            be_new    = 4'b0001 << bus.addr[1:0];
            wdata_rep = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            misaligned = bus.addr[0];
            be_new     = 4'b0011 << bus.addr[1:0];
            wdata_rep  = {2{bus.wdata[15:0]}};
         end
         2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Pick the addressed lane out of the SRAM word and extend it.
   always_comb begin
      byte_sel = bus.data_sram_rdata[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
         default: load_ext = bus.data_sram_rdata;
      endcase
   end

   // Next-state logic and datapath register updates for the transaction FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      accept       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               accept = 1'b1;
               if (misaligned) begin
                  state_d = DONE;
               end else begin
                  state_d     = ACCESS;
                  sram_addr_d = {bus.addr[31:2], 2'b00};
                  if (bus.wr) sram_wdata_d = wdata_rep;
               end
            end
         end
         ACCESS: begin
            if (wr_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = 3'(RD_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rdata_d = load_ext;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, counter and SRAM-facing registers; reset aborts any transaction.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         rdata_q      <= 32'h0;
         sram_addr_q  <= 32'h0;
         sram_wdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
      end
   end

   // Capture the request attributes when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q   <= 1'b0;
         sext_q <= 1'b0;
         err_q  <= 1'b0;
         size_q <= 2'b00;
         lane_q <= 2'b00;
         be_q   <= 4'b0000;
      end else if (accept) begin
         wr_q   <= bus.wr;
         sext_q <= bus.sext;
         err_q  <= misaligned;
         size_q <= bus.size;
         lane_q <= bus.addr[1:0];
         be_q   <= be_new;
      end
   end

   // en/wen come straight from the state, so reset drops them immediately.
   assign bus.busy            = (state_q != IDLE);
   assign bus.ack             = (state_q == DONE);
   assign bus.addr_err        = (state_q == DONE) && err_q;
   assign bus.rdata           = rdata_q;
   assign bus.data_sram_en    = (state_q == ACCESS);
   assign bus.data_sram_wen   = ((state_q == ACCESS) && wr_q) ? be_q : 4'b0000;
   assign bus.data_sram_addr  = sram_addr_q;
   assign bus.data_sram_wdata = sram_wdata_q;
   assign dbg_state_o         = state_q;

endmodule
